// File: rtl/usb_rx_pkg.sv
// Shared types and constants for the USB receive byte assembler.
// USB_RX_STUFF_CHECK_EN adds the ABORT state used on stuff violations.
package usb_rx_pkg;

    localparam int unsigned BYTE_W = 8;
    localparam logic [BYTE_W-1:0] SYNC_BYTE = 8'h80;

    typedef enum logic [1:0] {
        StIdle,
        StHunt,
        StReceive
`ifdef USB_RX_STUFF_CHECK_EN
        , StAbort
`endif
    } rx_state_e;

endpackage

// File: rtl/usb_rx_byte_assembler_if.sv
// Bit-stream inputs and byte-level results between the stuff-bit detector,
// the assembler and the RX controller.
interface usb_rx_byte_assembler_if #(
    parameter int unsigned CNT_W = 7
);
    import usb_rx_pkg::*;

    logic              shift_enable;
    logic              d_orig;
    logic              stuff_bit_indicator;
    logic              eop;
    logic [BYTE_W-1:0] rx_byte;
    logic              byte_valid;
    logic [CNT_W-1:0]  byte_count;
    logic              packet_done;
    logic              stuff_error;
    logic              align_error;

    modport master (
        output shift_enable, d_orig, stuff_bit_indicator, eop,
        input  rx_byte, byte_valid, byte_count, packet_done, stuff_error, align_error
    );

    modport slave (
        input  shift_enable, d_orig, stuff_bit_indicator, eop,
        output rx_byte, byte_valid, byte_count, packet_done, stuff_error, align_error
    );

endinterface

// File: rtl/usb_rx_byte_assembler_flex_counter.sv
// Generic wrap-around counter: counts 0..rollover_val then back to 0; clear wins.
module flex_counter #(
    parameter int unsigned NUM_CNT_BITS = 4
) (
    input  logic                    clk,
    input  logic                    n_rst,
    input  logic                    clear,
    input  logic                    count_enable,
    input  logic [NUM_CNT_BITS-1:0] rollover_val,
    output logic [NUM_CNT_BITS-1:0] count_out,
    output logic                    rollover_flag
);

    logic [NUM_CNT_BITS-1:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_enable) begin
            count_d = (count_q == rollover_val) ? '0 : count_q + NUM_CNT_BITS'(1);
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_out     = count_q;
    assign rollover_flag = (count_q == rollover_val);

endmodule

// File: rtl/usb_rx_byte_assembler.sv
// Hunts for SYNC, drops stuffed bits and assembles LSB-first payload bytes.
// USB_RX_STUFF_CHECK_EN enables stuff-violation detection and the ABORT state.
module usb_rx_byte_assembler
    import usb_rx_pkg::*;
#(
    parameter int unsigned CNT_W = 7
) (
    input logic                    clk,
    input logic                    n_rst,
    usb_rx_byte_assembler_if.slave bus
);

    rx_state_e         state_q, state_d;
    logic [BYTE_W-1:0] shift_reg_q, shift_reg_d;
    logic [BYTE_W-1:0] rx_byte_q, rx_byte_d;
    logic [CNT_W-1:0]  byte_count_q, byte_count_d;
    logic              byte_valid_q, byte_valid_d;
    logic              packet_done_q, packet_done_d;
    logic              align_error_q, align_error_d;
    logic [2:0]        bit_cnt;
    logic              bit_rollover;
    logic              accept, shift_en, sync_match, rx_accept, byte_done, eop_rx;
`ifdef USB_RX_STUFF_CHECK_EN
    logic              stuff_error_q, stuff_error_d;
    logic              stuff_evt;
`endif

    // eop outranks a coincident strobe, so such a bit is never accepted
    assign accept = bus.shift_enable & ~bus.stuff_bit_indicator & ~bus.eop;
`ifdef USB_RX_STUFF_CHECK_EN
    assign shift_en  = accept & (state_q != StAbort);
    assign stuff_evt = (state_q == StReceive) & bus.shift_enable & bus.stuff_bit_indicator &
                       ~bus.eop & bus.d_orig;
`else
    assign shift_en  = accept;
`endif
    assign rx_accept = (state_q == StReceive) & accept;
    assign byte_done = rx_accept & bit_rollover;
    assign eop_rx    = (state_q == StReceive) & bus.eop;

    // Match on the updated window so a back-to-back strobe after SYNC is not lost
    assign sync_match = (state_q == StHunt) & shift_en & (shift_reg_d == SYNC_BYTE);

    flex_counter #(
        .NUM_CNT_BITS (3)
    ) u_bit_cnt (
        .clk           (clk),
        .n_rst         (n_rst),
        .clear         (sync_match | bus.eop),
        .count_enable  (rx_accept),
        .rollover_val  (3'd7),
        .count_out     (bit_cnt),
        .rollover_flag (bit_rollover)
    );

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.shift_enable && !bus.eop) state_d = StHunt;
            end
            StHunt: begin
                if (bus.eop) state_d = StIdle;
                else if (sync_match) state_d = StReceive;
            end
            StReceive: begin
                if (bus.eop) state_d = StIdle;
`ifdef USB_RX_STUFF_CHECK_EN
                else if (stuff_evt) state_d = StAbort;
`endif
            end
`ifdef USB_RX_STUFF_CHECK_EN
            StAbort: begin
                if (bus.eop) state_d = StIdle;
            end
`endif
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        shift_reg_d   = shift_en ? {bus.d_orig, shift_reg_q[BYTE_W-1:1]} : shift_reg_q;
        rx_byte_d     = byte_done ? shift_reg_d : rx_byte_q;
        byte_valid_d  = byte_done;
        packet_done_d = eop_rx & (bit_cnt == 3'd0);
        byte_count_d  = byte_count_q;
        if (sync_match) begin
            byte_count_d = '0;
        end else if (byte_done && byte_count_q != {CNT_W{1'b1}}) begin
            byte_count_d = byte_count_q + CNT_W'(1);
        end
        align_error_d = align_error_q;
        if (sync_match) begin
            align_error_d = 1'b0;
        end else if (eop_rx && bit_cnt != 3'd0) begin
            align_error_d = 1'b1;
        end
`ifdef USB_RX_STUFF_CHECK_EN
        stuff_error_d = stuff_error_q;
        if (sync_match) begin
            stuff_error_d = 1'b0;
        end else if (stuff_evt) begin
            stuff_error_d = 1'b1;
        end
`endif
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            shift_reg_q   <= '0;
            rx_byte_q     <= '0;
            byte_count_q  <= '0;
            byte_valid_q  <= 1'b0;
            packet_done_q <= 1'b0;
            align_error_q <= 1'b0;
        end else begin
            shift_reg_q   <= shift_reg_d;
            rx_byte_q     <= rx_byte_d;
            byte_count_q  <= byte_count_d;
            byte_valid_q  <= byte_valid_d;
            packet_done_q <= packet_done_d;
            align_error_q <= align_error_d;
        end
    end

`ifdef USB_RX_STUFF_CHECK_EN
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            stuff_error_q <= 1'b0;
        end else begin
            stuff_error_q <= stuff_error_d;
        end
    end
    assign bus.stuff_error = stuff_error_q;
`else
    assign bus.stuff_error = 1'b0;
`endif

    assign bus.rx_byte     = rx_byte_q;
    assign bus.byte_valid  = byte_valid_q;
    assign bus.byte_count  = byte_count_q;
    assign bus.packet_done = packet_done_q;
    assign bus.align_error = align_error_q;

endmodule

// File: tb/tb_usb_rx_byte_assembler.sv
// Bench for usb_rx_byte_assembler: directed table, corner sequences and random
// packets compared against a bit-queue reference model.
module tb_usb_rx_byte_assembler;

    localparam int unsigned CNT_W   = 7;
    localparam int unsigned CNT_MAX = (1 << CNT_W) - 1;
    localparam int M_IDLE = 0, M_HUNT = 1, M_RECV = 2, M_ABORT = 3;
`ifdef USB_RX_STUFF_CHECK_EN
    localparam bit STUFF_EN = 1'b1;
`else
    localparam bit STUFF_EN = 1'b0;
`endif

    typedef struct {
        logic se, d, st, eop;
        logic bv;
        logic [7:0] rx;
        int unsigned cnt;
        logic pd, ae;
    } vec_t;

    logic clk = 1'b0;
    logic n_rst;
    int   checks = 0;
    int   errors = 0;

    usb_rx_byte_assembler_if #(.CNT_W(CNT_W)) bus ();

    usb_rx_byte_assembler #(
        .CNT_W (CNT_W)
    ) dut (
        .clk   (clk),
        .n_rst (n_rst),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    // Reference model: last eight accepted bits, payload bits since SYNC
    int          m_mode;
    bit          hist[$];
    bit          pay[$];
    logic [7:0]  m_rx;
    int unsigned m_cnt;
    bit          m_bv, m_pd, m_serr, m_ae;
    vec_t        tbl[$];

    function automatic void model_reset();
        hist.delete();
        for (int i = 0; i < 8; i++) hist.push_back(1'b0);
        pay.delete();
        m_mode = M_IDLE; m_rx = 8'h00; m_cnt = 0;
        m_bv = 0; m_pd = 0; m_serr = 0; m_ae = 0;
    endfunction

    function automatic void push_hist(input bit b);
        hist.push_back(b);
        if (hist.size() > 8) void'(hist.pop_front());
    endfunction

    function automatic bit window_is_sync();
        for (int i = 0; i < 7; i++) if (hist[i] != 1'b0) return 1'b0;
        return hist[7] == 1'b1;
    endfunction

    function automatic void model_step(input bit se, input bit d, input bit st, input bit e);
        bit acc;
        acc  = se && !st && !e;
        m_bv = 0;
        m_pd = 0;
        case (m_mode)
            M_IDLE: begin
                if (acc) push_hist(d);
                if (se && !e) m_mode = M_HUNT;
            end
            M_HUNT: begin
                if (e) m_mode = M_IDLE;
                else if (acc) begin
                    push_hist(d);
                    if (window_is_sync()) begin
                        m_mode = M_RECV; pay.delete(); m_cnt = 0; m_serr = 0; m_ae = 0;
                    end
                end
            end
            M_RECV: begin
                if (e) begin
                    m_mode = M_IDLE;
                    if (pay.size() == 0) m_pd = 1;
                    else m_ae = 1;
                    pay.delete();
                end else if (acc) begin
                    push_hist(d);
                    pay.push_back(d);
                    if (pay.size() == 8) begin
                        for (int i = 0; i < 8; i++) m_rx[i] = pay[i];
                        m_bv = 1;
                        if (m_cnt < CNT_MAX) m_cnt++;
                        pay.delete();
                    end
                end else if (STUFF_EN && se && st && d) begin
                    m_serr = 1;
                    m_mode = M_ABORT;
                end
            end
            default: if (e) m_mode = M_IDLE;
        endcase
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input bit se, input bit d, input bit st, input bit e);
        bus.shift_enable        = se;
        bus.d_orig              = d;
        bus.stuff_bit_indicator = st;
        bus.eop                 = e;
        @(posedge clk);
        #1;
        model_step(se, d, st, e);
        check("model_byte_valid", 32'(bus.byte_valid), 32'(m_bv));
        check("model_rx_byte", 32'(bus.rx_byte), 32'(m_rx));
        check("model_byte_count", 32'(bus.byte_count), m_cnt);
        check("model_packet_done", 32'(bus.packet_done), 32'(m_pd));
        check("model_align_error", 32'(bus.align_error), 32'(m_ae));
        check("model_stuff_error", 32'(bus.stuff_error), 32'(m_serr));
    endtask

    task automatic send_byte(input logic [7:0] b);
        for (int i = 0; i < 8; i++) step(1'b1, b[i], 1'b0, 1'b0);
    endtask

    task automatic eop_gap();
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_rx_byte"}, 32'(bus.rx_byte), 32'h0);
        check({tag, "_byte_valid"}, 32'(bus.byte_valid), 32'h0);
        check({tag, "_byte_count"}, 32'(bus.byte_count), 32'h0);
        check({tag, "_packet_done"}, 32'(bus.packet_done), 32'h0);
        check({tag, "_stuff_error"}, 32'(bus.stuff_error), 32'h0);
        check({tag, "_align_error"}, 32'(bus.align_error), 32'h0);
    endtask

    function automatic void add(input logic se, input logic d, input logic e, input logic bv,
                                input logic [7:0] rx, input int unsigned cnt, input logic pd);
        vec_t v;
        v.se = se; v.d = d; v.st = 1'b0; v.eop = e;
        v.bv = bv; v.rx = rx; v.cnt = cnt; v.pd = pd; v.ae = 1'b0;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [7:0] sync_bits;
        logic [7:0] a5_bits;
        bit         bv_seen;

        n_rst = 1'b0;
        bus.shift_enable = 1'b0; bus.d_orig = 1'b0;
        bus.stuff_bit_indicator = 1'b0; bus.eop = 1'b0;
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("reset");
        n_rst = 1'b1;

        // SYNC (0000_0001 in time order) then 1010_0101, then eop
        sync_bits = 8'h80;
        a5_bits   = 8'hA5;
        for (int i = 0; i < 8; i++) add(1'b1, sync_bits[i], 1'b0, 1'b0, 8'h00, 0, 1'b0);
        for (int i = 0; i < 7; i++) add(1'b1, a5_bits[i], 1'b0, 1'b0, 8'h00, 0, 1'b0);
        add(1'b1, a5_bits[7], 1'b0, 1'b1, 8'hA5, 1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b1);
        add(1'b0, 1'b0, 1'b1, 1'b0, 8'hA5, 1, 1'b0);
        add(1'b0, 1'b0, 1'b0, 1'b0, 8'hA5, 1, 1'b0);
        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].se, tbl[i].d, tbl[i].st, tbl[i].eop);
            check("tbl_byte_valid", 32'(bus.byte_valid), 32'(tbl[i].bv));
            check("tbl_rx_byte", 32'(bus.rx_byte), 32'(tbl[i].rx));
            check("tbl_byte_count", 32'(bus.byte_count), tbl[i].cnt);
            check("tbl_packet_done", 32'(bus.packet_done), 32'(tbl[i].pd));
            check("tbl_align_error", 32'(bus.align_error), 32'(tbl[i].ae));
        end

        // Stuff removal: six 1s, stuffed 0, then 1,0 -> seven 1s then 0
        eop_gap();
        send_byte(8'h80);
        repeat (6) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b1, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        check("stuff_rm_rx_byte", 32'(bus.rx_byte), 32'h7F);
        check("stuff_rm_byte_valid", 32'(bus.byte_valid), 32'h1);
        check("stuff_rm_no_error", 32'(bus.stuff_error), 32'h0);

        // Stuff strobe carrying a 1
        eop_gap();
        send_byte(8'h80);
        step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b0, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b0);
`ifdef USB_RX_STUFF_CHECK_EN
        check("stuff_viol_error", 32'(bus.stuff_error), 32'h1);
        bv_seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1'b1, 1'($urandom), 1'b0, 1'b0);
            bv_seen |= bus.byte_valid;
        end
        check("stuff_viol_no_byte", 32'(bv_seen), 32'h0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("stuff_viol_no_done", 32'(bus.packet_done), 32'h0);
        check("stuff_viol_sticky", 32'(bus.stuff_error), 32'h1);
`else
        check("stuff_off_no_error", 32'(bus.stuff_error), 32'h0);
        bv_seen = 1'b0;
        for (int i = 0; i < 6; i++) begin
            step(1'b1, 1'b1, 1'b0, 1'b0);
            bv_seen |= bus.byte_valid;
        end
        check("stuff_off_byte", 32'(bv_seen), 32'h1);
        check("stuff_off_rx_byte", 32'(bus.rx_byte), 32'hFD);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("stuff_off_done", 32'(bus.packet_done), 32'h1);
`endif

        // Misaligned EOP: one byte plus three bits
        eop_gap();
        send_byte(8'h80);
        send_byte(8'h5A);
        repeat (3) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("misalign_align_error", 32'(bus.align_error), 32'h1);
        check("misalign_no_done", 32'(bus.packet_done), 32'h0);
        check("misalign_count", 32'(bus.byte_count), 32'h1);

        // eop together with the 8th strobe
        eop_gap();
        send_byte(8'h80);
        repeat (7) step(1'b1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b0, 1'b1);
        check("coinc_no_byte_valid", 32'(bus.byte_valid), 32'h0);
        check("coinc_align_error", 32'(bus.align_error), 32'h1);
        check("coinc_no_done", 32'(bus.packet_done), 32'h0);

        // 130 back-to-back bytes saturate the count
        eop_gap();
        send_byte(8'h80);
        check("sync_clears_align", 32'(bus.align_error), 32'h0);
        repeat (130) send_byte(8'($urandom));
        check("sat_count", 32'(bus.byte_count), CNT_MAX);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("sat_done", 32'(bus.packet_done), 32'h1);

        // Asynchronous reset mid-packet
        eop_gap();
        send_byte(8'h80);
        send_byte(8'h3C);
        repeat (4) step(1'b1, 1'b0, 1'b0, 1'b0);
        n_rst = 1'b0;
        #1;
        check_all_zero("midreset");
        model_reset();
        @(posedge clk);
        #1;
        n_rst = 1'b1;
        send_byte(8'h80);
        send_byte(8'hC3);
        check("post_reset_rx_byte", 32'(bus.rx_byte), 32'hC3);
        check("post_reset_count", 32'(bus.byte_count), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1);
        check("post_reset_done", 32'(bus.packet_done), 32'h1);

        // Random packets against the model
        for (int p = 0; p < 60; p++) begin
            eop_gap();
            if ($urandom_range(3) != 0) send_byte(8'h80);
            for (int c = 0; c < int'($urandom_range(40)); c++) begin
                step(($urandom_range(3) != 0), 1'($urandom), ($urandom_range(9) == 0), 1'b0);
            end
            step(1'($urandom), 1'($urandom), 1'($urandom), 1'b1);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
